// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the async FIFO; skid buffer feeding a valid/ready stream.
// Define FIFO_RD_STREAM_STATS_EN to add the word_cnt/stall_cnt outputs.
module fifo_rd_stream #(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [WIDTH-1:0]             fifo_data_out,
    output logic                         fifo_read_en,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [$clog2(BUF_DEPTH):0]   buf_level
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]                  word_cnt,
    output logic [31:0]                  stall_cnt
`endif
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
    localparam logic [IW-1:0] LAST  = IW'(BUF_DEPTH - 1);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [CW-1:0]    count;
    logic             inflight, capture, pop;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return i == LAST ? '0 : i + 1'b1;
    endfunction

    // Reserving a slot for the in-flight word keeps m_ready out of the read path.
    assign fifo_read_en = !rst && !flush && !fifo_empty && (count + CW'(inflight) < DEPTH);
    assign capture      = inflight && !flush;
    assign pop          = m_valid && m_ready && !flush;
    assign m_valid      = count != '0;
    assign m_data       = mem[rd_idx];
    assign buf_level    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read_en;
            if (capture) begin
                mem[wr_idx] <= fifo_data_out;
                wr_idx      <= nxt(wr_idx);
            end
            if (pop) rd_idx <= nxt(rd_idx);
            count <= count + CW'(capture) - CW'(pop);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(capture && count == DEPTH));

`ifdef FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            word_cnt  <= word_cnt + 32'(m_valid && m_ready);
            stall_cnt <= stall_cnt + 32'(m_valid && !m_ready);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model plus in-order scoreboard around fifo_rd_stream, with directed and random phases.
module tb_fifo_rd_stream;
    localparam int W = 32;
    localparam int D = 4;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, m_ready = 1'b0;
    logic fifo_empty, fifo_read_en, m_valid;
    logic [W-1:0] fifo_data_out = '0, m_data;
    logic [$clog2(D):0] buf_level;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt, stall_cnt;
`endif

    int n_tests = 0, n_fail = 0;
    logic [W-1:0] src [4096];
    int wr_ptr = 0, rd_ptr = 0, n_reads = 0, n_pops = 0;
    logic [W-1:0] exp_q [$];
    logic stalled = 1'b0;
    logic [W-1:0] held = '0;

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_read_en(fifo_read_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .buf_level(buf_level)
`ifdef FIFO_RD_STREAM_STATS_EN
        , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign fifo_empty = rd_ptr == wr_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO with one-cycle read latency; every word read is owed downstream unless flushed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
            exp_q.delete();
        end else begin
            if (flush) exp_q.delete();
            if (fifo_read_en) begin
                fifo_data_out <= src[rd_ptr % 4096];
                exp_q.push_back(src[rd_ptr % 4096]);
                rd_ptr  <= rd_ptr + 1;
                n_reads <= n_reads + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            check("valid_vs_level", m_valid, buf_level != 0);
            check("level_max", buf_level <= D, 1);
            if (stalled) check("hold", m_data, held);
            if (m_valid && m_ready && !flush) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
                n_pops++;
            end
            stalled = m_valid && !m_ready && !flush;
            held = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        src[wr_ptr % 4096] = d;
        wr_ptr++;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !fifo_empty || m_valid) && k < 300) begin
            tick();
            k++;
        end
        check(tag, k < 300, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base, pushed;
`ifdef FIFO_RD_STREAM_STATS_EN
        logic [31:0] w0, s0;
`endif
        repeat (2) tick();
        check("rst_valid", m_valid, 0);
        check("rst_rd_en", fifo_read_en, 0);
        check("rst_level", buf_level, 0);
        check("rst_data", m_data, 0);
        rst = 1'b0;
        m_ready = 1'b1;

        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        @(negedge clk);
        check("first_rd_en", fifo_read_en, 1);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2);
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", m_valid, 1);
            check("stream_data", m_data, 32'hA0 + i);
            @(negedge clk);
        end
        check("stream_done", m_valid, 0);

        tick();
        m_ready = 1'b0;
        base = n_reads;
        for (int i = 0; i < 10; i++) push(32'hA0 + i);
        repeat (10) tick();
        @(negedge clk);
        check("bp_reads", n_reads - base, 4);
        check("bp_level", buf_level, 4);
        check("bp_data", m_data, 32'hA0);
        check("bp_rd_en", fifo_read_en, 0);
        tick();
        m_ready = 1'b1;
        base = n_pops;
        @(negedge clk);
        check("bp_resume0", fifo_read_en, 0);
        @(negedge clk);
        check("bp_resume1", fifo_read_en, 1);
        drain("bp_drain");
        check("bp_pops", n_pops - base, 10);

        pushed = 0;
        base = n_pops;
        for (int c = 0; c < 20000 && pushed < 1000; c++) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push($urandom);
                pushed++;
            end
        end
        tick();
        m_ready = 1'b1;
        drain("rand_drain");
        check("rand_pops", n_pops - base, 1000);

        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'hC0 + i);
        repeat (6) tick();
        check("fl_level3", buf_level, 3);
        for (int i = 3; i < 6; i++) push(32'hC0 + i);
        @(negedge clk);
        check("fl_rd", fifo_read_en, 1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("fl_rd_blocked", fifo_read_en, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_valid", m_valid, 0);
        check("fl_level", buf_level, 0);
        tick();
        m_ready = 1'b1;
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("fl_next_data", m_data, 32'hC4);
        drain("fl_drain");

        for (int i = 0; i < 20; i++) push(32'hD0 + i);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("rr_valid", m_valid, 0);
        check("rr_rd_en", fifo_read_en, 0);
        check("rr_level", buf_level, 0);
        tick();
        tick();
        rst = 1'b0;
        lat = 0;
        repeat (10) begin
            @(negedge clk);
            lat += int'(m_valid || fifo_read_en);
        end
        check("rr_idle", lat, 0);
        tick();
        push(32'hE0);
        drain("rr_drain");

`ifdef FIFO_RD_STREAM_STATS_EN
        w0 = word_cnt;
        s0 = stall_cnt;
`endif
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'hF0 + i);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 20);
        check("st_valid", m_valid, 1);
        repeat (4) @(negedge clk);
        tick();
        m_ready = 1'b1;
        drain("st_drain");
`ifdef FIFO_RD_STREAM_STATS_EN
        check("word_cnt", word_cnt - w0, 8);
        check("stall_cnt", stall_cnt - s0, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
